// File: rtl/edge_detect_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect_scheduler
// Description : One Mealy transition detector time-shared by N_CH serial bit
//               channels. A round-robin arbiter takes at most one sample per
//               cycle, runs it through the channel's stored detector state
//               and posts the result on a valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect_scheduler #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  ch_valid,
  input  logic [N_CH-1:0]  ch_bit,
  output logic [N_CH-1:0]  ch_ready,
  input  logic [N_CH-1:0]  ch_clr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CH_W-1:0]  res_ch,
  output logic             res_bit,
  output logic             res_out,
  output logic [CNT_W-1:0] edge_cnt
);

  // Detector state per channel; the unused 2'b00 encoding behaves like INIT
  // because only LAST0/LAST1 can ever produce an output.
  typedef enum logic [1:0] {
    ST_INIT  = 2'b01,
    ST_LAST0 = 2'b10,
    ST_LAST1 = 2'b11
  } det_state_e;

  localparam logic [CH_W:0]    c_n_ch    = (CH_W+1)'(N_CH);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CH_W-1:0]  c_ptr_rst = CH_W'(N_CH - 1);

  det_state_e      r_state [N_CH];
  logic [CH_W-1:0] r_ptr;

  logic            w_slot_free;
  logic            w_gnt_found;
  logic [CH_W-1:0] w_gnt_idx;
  logic [CH_W:0]   w_sum;
  logic [CH_W-1:0] w_idx;
  logic            w_bit;
  logic            w_out;

  // The result register can accept a new sample when empty or being drained.
  assign w_slot_free = !res_valid || res_ready;

  // Round-robin search from pointer+1, wrapping modulo N_CH; cleared channels
  // are skipped so their sample stays pending at the source.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_sum       = '0;
    w_idx       = '0;
    ch_ready    = '0;
    if (w_slot_free) begin
      for (int k = 1; k <= N_CH; k++) begin
        w_sum = {1'b0, r_ptr} + (CH_W+1)'(k);
        if (w_sum >= c_n_ch) begin
          w_sum = w_sum - c_n_ch;
        end
        w_idx = w_sum[CH_W-1:0];
        if (!w_gnt_found && ch_valid[w_idx] && !ch_clr[w_idx]) begin
          w_gnt_found = 1'b1;
          w_gnt_idx   = w_idx;
        end
      end
      if (w_gnt_found) begin
        ch_ready[w_gnt_idx] = 1'b1;
      end
    end
  end

  // Mealy output for the granted sample: a change from the last seen bit.
  always_comb begin
    w_bit = ch_bit[w_gnt_idx];
    w_out = ((r_state[w_gnt_idx] == ST_LAST0) &&  w_bit) ||
            ((r_state[w_gnt_idx] == ST_LAST1) && !w_bit);
  end

  // Per-channel detector state: clear wins over a same-cycle grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_state[i] <= ST_INIT;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_clr[i]) begin
          r_state[i] <= ST_INIT;
        end else if (w_gnt_found && (w_gnt_idx == CH_W'(i))) begin
          r_state[i] <= w_bit ? ST_LAST1 : ST_LAST0;
        end
      end
    end
  end

  // Arbitration pointer moves only on a grant so idle cycles keep the order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= c_ptr_rst;
    end else if (w_gnt_found) begin
      r_ptr <= w_gnt_idx;
    end
  end

  // Result register: load on grant, release on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_bit   <= 1'b0;
      res_out   <= 1'b0;
    end else if (w_gnt_found) begin
      res_valid <= 1'b1;
      res_ch    <= w_gnt_idx;
      res_bit   <= w_bit;
      res_out   <= w_out;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Saturating count of detected transitions entering the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (w_gnt_found && w_out && (edge_cnt != c_cnt_max)) begin
      edge_cnt <= edge_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edge_detect_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_detect_scheduler
// Description : Self-checking bench for edge_detect_scheduler (4 channels,
//               3-bit counter so saturation is reachable).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_detect_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ch_valid, ch_bit, ch_ready, ch_clr;
  logic       res_valid, res_ready, res_bit, res_out;
  logic [1:0] res_ch;
  logic [2:0] edge_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic       b;
    logic       o;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic [3:0] valid;
    logic [3:0] bits;
    logic [3:0] clr;
    logic       rdy;
    logic [3:0] exp_grant;
    logic       exp_out;
  } vec_t;

  edge_detect_scheduler #(.N_CH(4), .CH_W(2), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .ch_valid(ch_valid), .ch_bit(ch_bit), .ch_ready(ch_ready), .ch_clr(ch_clr),
    .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
    .res_bit(res_bit), .res_out(res_out), .edge_cnt(edge_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive, check grant and any consumed result mid-cycle, push the
  // expected result of this cycle's grant, then advance past the clock edge.
  task automatic step(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c,
                      input logic rdy, input logic [3:0] eg, input logic eo);
    exp_t e;
    ch_valid  = v;
    ch_bit    = b;
    ch_clr    = c;
    res_ready = rdy;
    @(negedge clk);
    chk("ch_ready", {4'h0, ch_ready}, {4'h0, eg});
    if (res_valid && res_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 8'h1, 8'h0);
      end else begin
        e = q.pop_front();
        chk("result{ch,bit,out}", {4'h0, res_ch, res_bit, res_out}, {4'h0, e});
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (eg[i]) begin
        e.ch = 2'(i);
        e.b  = b[i];
        e.o  = eo;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ch_valid  = '0;
    ch_bit    = '0;
    ch_clr    = '0;
    res_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("rst_res_valid", {7'h0, res_valid}, 8'h0);
    chk("rst_edge_cnt", {5'h0, edge_cnt}, 8'h0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || res_valid) && n < 20) begin
      step(4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0);
      n++;
    end
    chk("drain_timeout", {7'h0, (q.size() != 0 || res_valid)}, 8'h0);
  endtask

  vec_t t1 [5];
  vec_t t2 [8];

  initial begin
    // Test 1: single channel 0,1,1,0 -> 0,1,0,1
    t1[0] = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0};
    t1[1] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1};
    t1[2] = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0};
    t1[3] = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b1};
    t1[4] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0};
    // Test 2: all channels valid; first lap bits 1 (INIT), second lap bits 0
    for (int i = 0; i < 8; i++) begin
      t2[i] = '{4'b1111, (i < 4) ? 4'b1111 : 4'b0000, 4'b0000, 1'b1,
                4'(1 << (i % 4)), (i >= 4)};
    end

    rst = 1'b1;
    ch_valid = '0; ch_bit = '0; ch_clr = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_res_valid", {7'h0, res_valid}, 8'h0);
    chk("reset_res_fields", {4'h0, res_ch, res_bit, res_out}, 8'h0);
    chk("reset_edge_cnt", {5'h0, edge_cnt}, 8'h0);

    foreach (t1[i]) step(t1[i].valid, t1[i].bits, t1[i].clr, t1[i].rdy, t1[i].exp_grant, t1[i].exp_out);
    drain();
    chk("t1_edge_cnt", {5'h0, edge_cnt}, 8'd2);

    do_reset();
    foreach (t2[i]) step(t2[i].valid, t2[i].bits, t2[i].clr, t2[i].rdy, t2[i].exp_grant, t2[i].exp_out);
    drain();
    chk("t2_edge_cnt", {5'h0, edge_cnt}, 8'd4);

    // Test 3: backpressure on a ch2 result (ch2 is LAST0 here)
    step(4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0);
      chk("t3_hold_valid", {7'h0, res_valid}, 8'h1);
      chk("t3_hold_fields", {4'h0, res_ch, res_bit, res_out}, {4'h0, 2'd2, 1'b1, 1'b1});
    end
    step(4'b0100, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1);
    chk("t3_b2b_valid", {7'h0, res_valid}, 8'h1);
    chk("t3_b2b_bit", {7'h0, res_bit}, 8'h0);
    drain();

    // Test 4: ch1 to LAST1, clear beats same-cycle sample, then INIT behaviour
    step(4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1);
    step(4'b0010, 4'b0000, 4'b0010, 1'b1, 4'b0000, 1'b0);
    step(4'b0010, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0);
    drain();

    // Test 5: 9 alternating bits on ch3 -> 8 edges, counter saturates at 7
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(4'b1000, (i % 2 == 1) ? 4'b1000 : 4'b0000, 4'b0000, 1'b1, 4'b1000, (i > 0));
    end
    drain();
    chk("t5_edge_cnt_sat", {5'h0, edge_cnt}, 8'd7);

    // Test 6: reset while a result is pending and ch0 is LAST1
    do_reset();
    step(4'b0001, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0);
    chk("t6_pending", {7'h0, res_valid}, 8'h1);
    do_reset();
    step(4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0);
    drain();
    chk("t6_edge_cnt", {5'h0, edge_cnt}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
